pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rstn  input  1  reset; synchronous, active-low.
REQ-004 Port: stall  input  1  ID stage cannot accept a new instruction this cycle (hazard unit).
REQ-005 Port: redirect_valid  input  1  ID-stage branch taken or jump (branch_occur | isjump from next-PC logic, qualified by ID valid).
REQ-006 Port: redirect_pc  input  32  target PC from next-PC logic.
REQ-007 Port: if_req  output  1  instruction-memory fetch request, held until if_ack.
REQ-008 Port: if_pc  output  32  fetch address; stable while if_req=1.
REQ-009 Port: if_ack  input  1  instruction-memory response valid; latency of 0 or more cycles after if_req.
REQ-010 Port: if_instr  input  32  fetched instruction; valid when if_ack=1.
REQ-011 Port: ifid_valid / ifid_pc / ifid_instr  output  1/32/32  IF/ID pipeline register contents.
REQ-012 Port: misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-013 The block SHALL implement an FSM with states IDLE, FETCH, HOLD and DRAIN.
REQ-014 IDLE: if_req=0; SHALL go to FETCH on the next cycle.
REQ-015 FETCH: if_req=1, if_pc=pc. On if_ack with stall=0: ifid <= {1, pc, if_instr}; pc <= pc+4; stay in FETCH. Back-to-back fetches give 1 instruction per cycle at zero memory latency.
REQ-016 FETCH, if_ack with stall=1: the instruction SHALL go to a one-entry skid register and the FSM SHALL go to HOLD. ifid is unchanged and if_req=0.
REQ-017 HOLD: when stall falls, skid -> ifid, pc <= pc+4, go to FETCH. No instruction is lost or duplicated.
REQ-018 While stall=1 and no skid transfer occurs, ifid SHALL hold its value.
REQ-019 redirect_valid SHALL be sampled only when stall=0, and it SHALL have priority over every other event in that cycle:
  - pc <= {redirect_pc[31:2], 2'b00}
  - ifid_valid <= 0 (flush)
  - skid cleared
REQ-020 Redirect in FETCH with if_ack=1 in the same cycle: the returned instruction is discarded; next state is FETCH at the new pc.
REQ-021 Redirect in FETCH with if_ack=0: next state is DRAIN. DRAIN keeps if_req=0 and discards the next if_ack, then goes to FETCH. A further redirect in DRAIN updates pc only.
REQ-022 Redirect in HOLD or IDLE: next state is FETCH at the new pc.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 misalign_err SHALL set on any accepted redirect with redirect_pc[1:0] != 0. It clears only on reset.
REQ-025 if_pc SHALL equal pc in FETCH. In IDLE, HOLD and DRAIN, if_req=0 and if_pc is don't-care.

Reset
REQ-026 On rstn=0 at a clock edge:
  - state = IDLE, pc = RESET_PC, if_req = 0
  - ifid_valid = 0, ifid_pc = 0, ifid_instr = 0
  - skid empty, misalign_err = 0
REQ-027 Reset mid-fetch SHALL abandon the outstanding request. Any if_ack arriving in the first cycle after reset SHALL be ignored.

Structure
REQ-028 FSM state encodings and the RESET_PC default SHALL live in the shared pipeline package.
REQ-029 The skid buffer SHALL be one sub-module, pc_skid_reg: 1-entry, valid plus 64-bit payload.
REQ-030 The block SHALL contain no next-PC arithmetic other than pc+4. Branch and jump target computation stays in the existing next-PC logic.

Verification
REQ-031 Reset release, if_ack tied to 1: if_pc sequence 0,4,8,C; ifid_valid rises 2 cycles after rstn rises.
REQ-032 if_ack at pc=8 while stall=1 for 3 cycles: ifid holds pc 4; after stall falls, ifid_pc=8 exactly once, then if_pc=C.
REQ-033 Redirect to 32'h0000_0040 with if_ack=1 in the same cycle: ifid_valid=0 next cycle; the next if_pc=40; the discarded instruction never appears in ifid.
REQ-034 Redirect to 32'h80 during a 3-cycle-latency fetch: FSM goes to DRAIN, the stale ack is dropped, then if_pc=80.
REQ-035 pc=32'hFFFF_FFFC fetched: next if_pc=0. Redirect to 32'h0000_0102: pc=100 and misalign_err=1 until reset.
REQ-036 rstn asserted in HOLD with a full skid: the next cycle shows state IDLE, pc=RESET_PC, skid empty, ifid_valid=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared pipeline definitions for the fetch sequencer: FSM encodings,
// the default reset PC and the sequential PC increment.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential fetch step; wraps naturally modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_skid_reg.sv
// One-entry skid register holding a {pc, instr} pair that arrived while
// the ID stage was stalled. Clear wins over load.
module pc_skid_reg (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        clear,
  input  logic [63:0] load_data,
  output logic        valid,
  output logic [63:0] data
);

  // Capture on load, empty on clear or reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
      data  <= 64'd0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: drives the instruction-memory request,
// fills the IF/ID register, parks a stalled response in a skid entry,
// and follows ID-stage redirects (flushing IF/ID and draining any
// request still in flight).
//
// Handshake: if_req is held high with if_pc stable until a cycle with
// if_ack=1, which completes the request and carries if_instr. Redirects
// are accepted only in cycles where stall=0.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_req,
  output logic [31:0] if_pc,
  input  logic        if_ack,
  input  logic [31:0] if_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        misalign_err,
  output pc_state_e   fsm_state,
  output logic        skid_full
);

  pc_state_e   state;
  logic [31:0] pc;
  logic        accept_redirect;
  logic [31:0] redirect_tgt;
  logic        skid_load;
  logic        skid_clear;
  logic [63:0] skid_data;

  // Redirect acceptance and skid control decoded from the current state.
  always_comb begin
    accept_redirect = redirect_valid & ~stall;
    redirect_tgt    = {redirect_pc[31:2], 2'b00};
    skid_load       = (state == ST_FETCH) & if_ack & stall;
    skid_clear      = accept_redirect | ((state == ST_HOLD) & ~stall);
  end

  pc_skid_reg u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data ({pc, if_instr}),
    .valid     (skid_full),
    .data      (skid_data)
  );

  assign if_pc     = pc;
  assign fsm_state = state;

  // Fetch FSM with registered request and IF/ID outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      if_req       <= 1'b0;
      ifid_valid   <= 1'b0;
      ifid_pc      <= 32'd0;
      ifid_instr   <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      if (accept_redirect && (redirect_pc[1:0] != 2'b00)) begin
        misalign_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          // Nothing to hand over; the consumed entry is dropped when ID moves.
          if (!stall) ifid_valid <= 1'b0;
          if (accept_redirect) pc <= redirect_tgt;
          state  <= ST_FETCH;
          if_req <= 1'b1;
        end
        ST_FETCH: begin
          if (accept_redirect) begin
            pc         <= redirect_tgt;
            ifid_valid <= 1'b0;
            if (!if_ack) begin
              // Old request still outstanding: wait for its response.
              state  <= ST_DRAIN;
              if_req <= 1'b0;
            end
          end else if (if_ack && !stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= pc;
            ifid_instr <= if_instr;
            pc         <= pc_inc(pc);
          end else if (if_ack && stall) begin
            state  <= ST_HOLD;
            if_req <= 1'b0;
          end else if (!stall) begin
            ifid_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          // pc still addresses the parked instruction until it moves on.
          if (accept_redirect) begin
            pc         <= redirect_tgt;
            ifid_valid <= 1'b0;
            state      <= ST_FETCH;
            if_req     <= 1'b1;
          end else if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= skid_data[63:32];
            ifid_instr <= skid_data[31:0];
            pc         <= pc_inc(pc);
            state      <= ST_FETCH;
            if_req     <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!stall) ifid_valid <= 1'b0;
          if (accept_redirect) pc <= redirect_tgt;
          if (if_ack) begin
            state  <= ST_FETCH;
            if_req <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          if_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: streaming after reset, stall/skid,
// redirect flush, drain of an in-flight fetch, wrap and misalignment,
// reset while holding a skid entry.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_req;
  logic [31:0] if_pc;
  logic        if_ack;
  logic [31:0] if_instr;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        misalign_err;
  pc_state_e   fsm_state;
  logic        skid_full;

  int n_pass;
  int n_total;

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  // Memory model: instruction word tagged with its address.
  assign if_instr = {16'hC0DE, if_pc[15:0]};

  pc_sequencer dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_req         (if_req),
    .if_pc          (if_pc),
    .if_ack         (if_ack),
    .if_instr       (if_instr),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .misalign_err   (misalign_err),
    .fsm_state      (fsm_state),
    .skid_full      (skid_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; if_ack = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Reset state, then streaming at zero latency.
  task automatic test_reset_stream();
    rstn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; if_ack = 1'b1;
    tick(); tick();
    n_total++; if (fsm_state !== ST_IDLE) $display("FAIL rst_state got %0d want %0d", fsm_state, ST_IDLE); else n_pass++;
    n_total++; if (if_req !== 1'b0) $display("FAIL rst_if_req got %b want 0", if_req); else n_pass++;
    n_total++; if (ifid_valid !== 1'b0) $display("FAIL rst_ifid_valid got %b want 0", ifid_valid); else n_pass++;
    n_total++; if (ifid_pc !== 32'd0) $display("FAIL rst_ifid_pc got %h want 0", ifid_pc); else n_pass++;
    n_total++; if (ifid_instr !== 32'd0) $display("FAIL rst_ifid_instr got %h want 0", ifid_instr); else n_pass++;
    n_total++; if (misalign_err !== 1'b0) $display("FAIL rst_misalign got %b want 0", misalign_err); else n_pass++;
    n_total++; if (skid_full !== 1'b0) $display("FAIL rst_skid got %b want 0", skid_full); else n_pass++;
    n_total++; if (if_pc !== 32'd0) $display("FAIL rst_pc got %h want 0", if_pc); else n_pass++;
    rstn = 1'b1;
    tick();
    n_total++; if (fsm_state !== ST_FETCH) $display("FAIL stream_state1 got %0d want %0d", fsm_state, ST_FETCH); else n_pass++;
    n_total++; if (if_req !== 1'b1 || if_pc !== 32'h0) $display("FAIL stream_pc0 got req=%b pc=%h want req=1 pc=0", if_req, if_pc); else n_pass++;
    n_total++; if (ifid_valid !== 1'b0) $display("FAIL stream_valid_early got %b want 0", ifid_valid); else n_pass++;
    tick();
    n_total++; if (if_pc !== 32'h4) $display("FAIL stream_pc4 got %h want 4", if_pc); else n_pass++;
    n_total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_instr !== 32'hC0DE_0000)
      $display("FAIL stream_ifid0 got v=%b pc=%h i=%h want v=1 pc=0 i=c0de0000", ifid_valid, ifid_pc, ifid_instr); else n_pass++;
    tick();
    n_total++; if (if_pc !== 32'h8 || ifid_pc !== 32'h4) $display("FAIL stream_pc8 got pc=%h ifid=%h want 8/4", if_pc, ifid_pc); else n_pass++;
    tick();
    n_total++; if (if_pc !== 32'hC || ifid_pc !== 32'h8) $display("FAIL stream_pcC got pc=%h ifid=%h want c/8", if_pc, ifid_pc); else n_pass++;
  endtask

  // Ack at pc=8 under a 3-cycle stall goes through the skid entry.
  task automatic test_stall_skid();
    do_reset();
    if_ack = 1'b1;
    tick(); tick(); tick();
    n_total++; if (if_pc !== 32'h8) $display("FAIL skid_pre_pc got %h want 8", if_pc); else n_pass++;
    stall = 1'b1;
    tick();
    n_total++; if (fsm_state !== ST_HOLD || if_req !== 1'b0 || skid_full !== 1'b1)
      $display("FAIL skid_enter got st=%0d req=%b skid=%b want st=2 req=0 skid=1", fsm_state, if_req, skid_full); else n_pass++;
    n_total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) $display("FAIL skid_hold1 got v=%b pc=%h want 1/4", ifid_valid, ifid_pc); else n_pass++;
    if_ack = 1'b0;
    tick(); tick();
    n_total++; if (fsm_state !== ST_HOLD || ifid_pc !== 32'h4 || ifid_valid !== 1'b1)
      $display("FAIL skid_hold3 got st=%0d v=%b pc=%h want 2/1/4", fsm_state, ifid_valid, ifid_pc); else n_pass++;
    stall = 1'b0;
    tick();
    n_total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8 || ifid_instr !== 32'hC0DE_0008)
      $display("FAIL skid_release got v=%b pc=%h i=%h want 1/8/c0de0008", ifid_valid, ifid_pc, ifid_instr); else n_pass++;
    n_total++; if (fsm_state !== ST_FETCH || if_req !== 1'b1 || if_pc !== 32'hC || skid_full !== 1'b0)
      $display("FAIL skid_resume got st=%0d req=%b pc=%h skid=%b want 1/1/c/0", fsm_state, if_req, if_pc, skid_full); else n_pass++;
    tick();
    n_total++; if (ifid_valid !== 1'b0 || if_pc !== 32'hC) $display("FAIL skid_no_dup got v=%b pc=%h want 0/c", ifid_valid, if_pc); else n_pass++;
    if_ack = 1'b1;
    tick();
    n_total++; if (ifid_pc !== 32'hC || if_pc !== 32'h10) $display("FAIL skid_next got ifid=%h pc=%h want c/10", ifid_pc, if_pc); else n_pass++;
  endtask

  // Redirect to 0x40 in the same cycle as an ack.
  task automatic test_redirect_ack();
    do_reset();
    if_ack = 1'b1;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (ifid_valid !== 1'b0) $display("FAIL redir_flush got %b want 0", ifid_valid); else n_pass++;
    n_total++; if (fsm_state !== ST_FETCH || if_pc !== 32'h40) $display("FAIL redir_pc got st=%0d pc=%h want 1/40", fsm_state, if_pc); else n_pass++;
    tick();
    n_total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h40 || ifid_instr !== 32'hC0DE_0040)
      $display("FAIL redir_first got v=%b pc=%h i=%h want 1/40/c0de0040", ifid_valid, ifid_pc, ifid_instr); else n_pass++;
    n_total++; if (if_pc !== 32'h44) $display("FAIL redir_next got %h want 44", if_pc); else n_pass++;
  endtask

  // Redirect to 0x80 during a 3-cycle-latency fetch.
  task automatic test_redirect_drain();
    do_reset();
    if_ack = 1'b0;
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (fsm_state !== ST_DRAIN || if_req !== 1'b0) $display("FAIL drain_enter got st=%0d req=%b want 3/0", fsm_state, if_req); else n_pass++;
    tick();
    n_total++; if (fsm_state !== ST_DRAIN) $display("FAIL drain_wait got %0d want 3", fsm_state); else n_pass++;
    if_ack = 1'b1;
    tick();
    n_total++; if (fsm_state !== ST_FETCH || if_pc !== 32'h80 || ifid_valid !== 1'b0)
      $display("FAIL drain_exit got st=%0d pc=%h v=%b want 1/80/0", fsm_state, if_pc, ifid_valid); else n_pass++;
    tick();
    n_total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h80 || ifid_instr !== 32'hC0DE_0080)
      $display("FAIL drain_first got v=%b pc=%h i=%h want 1/80/c0de0080", ifid_valid, ifid_pc, ifid_instr); else n_pass++;
  endtask

  // Redirect ignored while stalled.
  task automatic test_stalled_redirect();
    do_reset();
    if_ack = 1'b0;
    tick();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h203;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    n_total++; if (fsm_state !== ST_FETCH || if_pc !== 32'h0 || misalign_err !== 1'b0)
      $display("FAIL stall_redir got st=%0d pc=%h mis=%b want 1/0/0", fsm_state, if_pc, misalign_err); else n_pass++;
  endtask

  // PC wrap and misaligned redirect target.
  task automatic test_wrap_misalign();
    do_reset();
    if_ack = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    n_total++; if (if_pc !== 32'hFFFF_FFFC || misalign_err !== 1'b0) $display("FAIL wrap_redir got pc=%h mis=%b want fffffffc/0", if_pc, misalign_err); else n_pass++;
    redirect_valid = 1'b0;
    tick();
    n_total++; if (if_pc !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC) $display("FAIL wrap got pc=%h ifid=%h want 0/fffffffc", if_pc, ifid_pc); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    n_total++; if (if_pc !== 32'h100 || misalign_err !== 1'b1 || ifid_valid !== 1'b0)
      $display("FAIL misalign got pc=%h mis=%b v=%b want 100/1/0", if_pc, misalign_err, ifid_valid); else n_pass++;
    tick(); tick();
    n_total++; if (misalign_err !== 1'b1 || if_pc !== 32'h108) $display("FAIL misalign_sticky got mis=%b pc=%h want 1/108", misalign_err, if_pc); else n_pass++;
  endtask

  // Reset in HOLD with a full skid (continues from the previous state).
  task automatic test_reset_in_hold();
    stall = 1'b1; if_ack = 1'b1;
    tick();
    n_total++; if (fsm_state !== ST_HOLD || skid_full !== 1'b1) $display("FAIL hold_setup got st=%0d skid=%b want 2/1", fsm_state, skid_full); else n_pass++;
    rstn = 1'b0;
    tick();
    n_total++; if (fsm_state !== ST_IDLE || if_pc !== 32'h0 || skid_full !== 1'b0 || ifid_valid !== 1'b0 || if_req !== 1'b0)
      $display("FAIL hold_reset got st=%0d pc=%h skid=%b v=%b req=%b want 0/0/0/0/0", fsm_state, if_pc, skid_full, ifid_valid, if_req); else n_pass++;
    n_total++; if (misalign_err !== 1'b0) $display("FAIL hold_reset_mis got %b want 0", misalign_err); else n_pass++;
    rstn = 1'b1; stall = 1'b0;
    tick();
    n_total++; if (ifid_valid !== 1'b0 || fsm_state !== ST_FETCH || if_pc !== 32'h0)
      $display("FAIL post_rst_ack got v=%b st=%0d pc=%h want 0/1/0", ifid_valid, fsm_state, if_pc); else n_pass++;
    tick();
    n_total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || if_pc !== 32'h4)
      $display("FAIL post_rst_fetch got v=%b ifid=%h pc=%h want 1/0/4", ifid_valid, ifid_pc, if_pc); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rstn = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; if_ack = 1'b0;
    test_reset_stream();
    test_stall_skid();
    test_redirect_ack();
    test_redirect_drain();
    test_stalled_redirect();
    test_wrap_misalign();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
